// File: rtl/tick_period_meter.sv
// Tick period meter: recovers the clk-cycle interval between
// rising edges of a (possibly asynchronous) pulse stream.
module tick_period_meter #(
   parameter int CNT_W       = 26,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             en,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             timeout,
   output logic             armed
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEAS
   } state_t;

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   tick_edge;
   logic [CNT_W-1:0]       cnt;
   state_t                 state;

   // Synchronize pulse_in and keep one extra flop of history for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // A held high level yields a single rising edge
   assign tick_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Measurement FSM: arm on first edge, then report each edge-to-edge gap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         armed        <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  cnt   <= '0;
                  state <= ARM;
                  armed <= 1'b1;
               end
               ARM: begin
                  if (tick_edge) begin
                     state <= MEAS;
                     cnt   <= ONE;
                  end
               end
               MEAS: begin
                  // An edge landing exactly on the limit still counts as a period
                  if (tick_edge) begin
                     period       <= cnt;
                     period_valid <= 1'b1;
                     cnt          <= ONE;
                  end else if (cnt == TO_CNT) begin
                     timeout <= 1'b1;
                     cnt     <= '0;
                     state   <= ARM;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  armed <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
